// File: rtl/fusion_pkg.sv
// fusion_pkg: shared FUSION geometry, pipeline latency and the
// frame-sequencer state type.
package fusion_pkg;

    localparam int PIXELS_PER_BEAT = 16;
    localparam int INPUT_WIDTH     = 8;
    localparam int IMAGE_DIM       = 512;
    localparam int BEATS_PER_FRAME =
        IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;

    // Must track the FUSION/HSSIM stage count:
    // 10 frame-delay stages + 3 fuse stages.
    localparam int FUSION_PIPE_LATENCY = 13;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fusion_state_e;

endpackage

// File: rtl/fusion_vld_pipe.sv
// fusion_vld_pipe: valid-token shift register with hold enable.
// Ports: clk, aresetn (sync, low), hold, din, vld[DEPTH-1:0].
module fusion_vld_pipe #(
    parameter int DEPTH = 13
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             hold,
    input  logic             din,
    output logic [DEPTH-1:0] vld
);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            vld <= '0;
        end else if (!hold) begin
            vld[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

endmodule

// File: rtl/fusion_stream_ctrl.sv
// fusion_stream_ctrl: FUSION frame sequencer and global stall.
// Ports: clk, aresetn, start/busy/done, s_valid/s_ready/s_last,
// m_valid/m_ready/m_last, stall, last_err, frame_cnt.
module fusion_stream_ctrl #(
    parameter int PIXELS_PER_BEAT = fusion_pkg::PIXELS_PER_BEAT,
    parameter int IMAGE_DIM       = fusion_pkg::IMAGE_DIM,
    parameter int PIPE_LATENCY    = fusion_pkg::FUSION_PIPE_LATENCY
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        stall,
    output logic        last_err,
    output logic [15:0] frame_cnt
);

    import fusion_pkg::*;

    localparam int BEATS_PER_FRAME =
        IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int CNT_W =
        (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT =
        CNT_W'(BEATS_PER_FRAME - 1);

    fusion_state_e           state;
    fusion_state_e           state_nx;
    logic [CNT_W-1:0]        in_cnt;
    logic [CNT_W-1:0]        out_cnt;
    logic [PIPE_LATENCY-1:0] vld;
    logic                    acc;
    logic                    hs;
    logic                    in_last;
    logic                    out_last;

    // Only a blocked output freezes the datapath, so bubbles
    // keep moving and no skid buffer is needed.
    assign m_valid  = vld[PIPE_LATENCY-1];
    assign stall    = m_valid & ~m_ready;
    assign s_ready  = (state == RUN) & ~stall;
    assign acc      = s_valid & s_ready;
    assign hs       = m_valid & m_ready;
    assign in_last  = (in_cnt == LAST_BEAT);
    assign out_last = (out_cnt == LAST_BEAT);
    assign m_last   = m_valid & out_last;
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

    fusion_vld_pipe #(
        .DEPTH (PIPE_LATENCY)
    ) u_vld_pipe (
        .clk     (clk),
        .aresetn (aresetn),
        .hold    (stall),
        .din     (acc),
        .vld     (vld)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (acc && in_last) state_nx = DRAIN;
            DRAIN:   if (hs && m_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            last_err  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                in_cnt   <= '0;
                out_cnt  <= '0;
                last_err <= 1'b0;
            end else begin
                if (acc) begin
                    in_cnt <= in_last ? '0 : in_cnt + 1'b1;
                end
                if (hs) begin
                    out_cnt <= out_last ? '0 : out_cnt + 1'b1;
                end
                // TLAST early, or missing on the final beat.
                if (acc && (s_last != in_last)) begin
                    last_err <= 1'b1;
                end
            end
            if (state == DONE) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fusion_stream_ctrl.sv
// tb_fusion_stream_ctrl: bench for fusion_stream_ctrl, small
// 4-beat frame instance plus a default-size instance.
module tb_fusion_stream_ctrl;

    localparam int B  = 4;
    localparam int L  = 13;
    localparam int BD = 16384;

    logic        clk;
    logic        aresetn;
    logic        start, s_valid, s_last, m_ready;
    logic        busy, done, s_ready, m_valid;
    logic        m_last, stall, last_err;
    logic [15:0] frame_cnt;

    logic        start_d, s_valid_d, s_last_d, m_ready_d;
    logic        busy_d, done_d, s_ready_d, m_valid_d;
    logic        m_last_d, stall_d, last_err_d;
    logic [15:0] frame_cnt_d;

    int vectors;
    int miscompares;

    // reference model state
    int q[$];
    int adv;
    int ms;
    int ins;
    int outs;
    int fc;
    bit err;

    fusion_stream_ctrl #(
        .PIXELS_PER_BEAT (16),
        .IMAGE_DIM       (8),
        .PIPE_LATENCY    (L)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .stall     (stall),
        .last_err  (last_err),
        .frame_cnt (frame_cnt)
    );

    fusion_stream_ctrl dut_d (
        .clk       (clk),
        .aresetn   (aresetn),
        .start     (start_d),
        .busy      (busy_d),
        .done      (done_d),
        .s_valid   (s_valid_d),
        .s_ready   (s_ready_d),
        .s_last    (s_last_d),
        .m_valid   (m_valid_d),
        .m_ready   (m_ready_d),
        .m_last    (m_last_d),
        .stall     (stall_d),
        .last_err  (last_err_d),
        .frame_cnt (frame_cnt_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Oldest beat reaches the output after L-1 further
    // non-stalled edges past its acceptance edge.
    function automatic bit mv_pred();
        return q.size() > 0 && (adv - q[0] == L - 1);
    endfunction

    task automatic step(input bit st, input bit sv,
                        input bit sl, input bit mr);
        bit mv_e, st_e, sr_e, ml_e, acc, hs;
        start   = st;
        s_valid = sv;
        s_last  = sl;
        m_ready = mr;
        #1;
        mv_e = mv_pred();
        st_e = mv_e & ~mr;
        sr_e = (ms == 1) & ~st_e;
        ml_e = mv_e & (outs == B - 1);
        chk("m_valid", m_valid, mv_e);
        chk("stall", stall, st_e);
        chk("s_ready", s_ready, sr_e);
        chk("m_last", m_last, ml_e);
        chk("busy", busy, (ms == 1 || ms == 2));
        chk("done", done, ms == 3);
        chk("last_err", last_err, err);
        chk("frame_cnt", frame_cnt, fc);
        @(posedge clk);
        #1;
        acc = sv & sr_e;
        hs  = mv_e & mr;
        if (hs) begin
            void'(q.pop_front());
            outs = (outs + 1) % B;
        end
        if (!st_e) adv++;
        if (acc) q.push_back(adv);
        case (ms)
            0: if (st) begin
                ms = 1; ins = 0; outs = 0; err = 0;
            end
            1: if (acc) begin
                if ((ins == B - 1) != sl) err = 1;
                if (ins == B - 1) begin
                    ms = 2; ins = 0;
                end else begin
                    ins++;
                end
            end
            2: if (hs && ml_e) ms = 3;
            default: begin
                fc = (fc + 1) & 16'hffff;
                ms = 0;
            end
        endcase
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        start   = 1'b1;
        s_valid = 1'b1;
        s_last  = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        adv = 0; ms = 0; ins = 0;
        outs = 0; fc = 0; err = 0;
        aresetn = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    // svm: 0 steady, 1 toggle, 2 random
    // mrm: 0 always ready, 1 five-cycle block, 2 random
    task automatic run_frame(input int svm, input int mrm,
                             input bit badl, input bit noise,
                             input int rst_at);
        int cyc  = 0;
        int hold = 0;
        bit armed = 1;
        bit sv, sl, mr, st;
        step(1, 0, 0, 1);
        while (ms != 0 && cyc < 400) begin
            if (cyc == rst_at) begin
                do_reset();
                return;
            end
            case (svm)
                0:       sv = 1;
                1:       sv = (cyc % 2 == 0);
                default: sv = 1'($urandom % 2);
            endcase
            sl = badl ? (ins == 1) : (ins == B - 1);
            case (mrm)
                0: mr = 1;
                1: begin
                    if (armed && mv_pred()) begin
                        hold = 5; armed = 0;
                    end
                    mr = (hold == 0);
                    if (hold > 0) hold--;
                end
                default: mr = 1'($urandom % 2);
            endcase
            st = noise ? 1'($urandom % 2) : 1'b0;
            step(st, sv, sl, mr);
            cyc++;
        end
        chk("frame_timeout", ms == 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
    endtask

    initial begin
        int acc_n, hs_n, ml_n, dn_n, cyc;
        vectors     = 0;
        miscompares = 0;
        start_d     = 1'b0;
        s_valid_d   = 1'b0;
        s_last_d    = 1'b0;
        m_ready_d   = 1'b1;
        do_reset();
        step(0, 0, 0, 1);

        run_frame(0, 0, 0, 0, -1);
        run_frame(0, 1, 0, 0, -1);
        run_frame(1, 0, 0, 0, -1);
        run_frame(0, 0, 1, 0, -1);
        run_frame(0, 0, 0, 0, -1);

        run_frame(0, 2, 0, 1, -1);
        run_frame(0, 0, 0, 0, 3);
        step(0, 0, 0, 1);
        run_frame(0, 0, 0, 0, -1);

        for (int f = 0; f < 6; f++) begin
            run_frame(2, 2, 1'($urandom % 2), 1, -1);
        end

        acc_n = 0; hs_n = 0; ml_n = 0;
        dn_n = 0; cyc = 0;
        start_d = 1'b1;
        @(posedge clk);
        #1;
        start_d = 1'b0;
        while (cyc < 50000 && (dn_n == 0 || cyc < 4)) begin
            s_valid_d = 1'b1;
            s_last_d  = (acc_n == BD - 1);
            m_ready_d = 1'($urandom % 2);
            #1;
            if (s_valid_d && s_ready_d) acc_n++;
            if (m_valid_d && m_ready_d) begin
                hs_n++;
                if (m_last_d) ml_n++;
            end
            if (done_d) dn_n++;
            @(posedge clk);
            #1;
            cyc++;
        end
        for (int i = 0; i < 3; i++) begin
            s_valid_d = 1'b0;
            #1;
            if (done_d) dn_n++;
            @(posedge clk);
            #1;
        end
        chk("big_in_beats", acc_n, BD);
        chk("big_out_beats", hs_n, BD);
        chk("big_m_last", ml_n, 1);
        chk("big_done", dn_n, 1);
        chk("big_frame_cnt", frame_cnt_d, 1);
        chk("big_last_err", last_err_d, 0);
        chk("big_busy", busy_d, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
